// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampled UART receiver with ready/valid output and error pulses.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif
  state_t state_q, state_d;
  logic                 meta_q, rxs_q;
  logic [1:0]           settle_q;
  logic                 armed_q, armed_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 mid;
`ifdef UART_RX_PARITY_EN
  logic                 pend_q, pend_d, perr_q, perr_d;
`endif
  assign mid = i_tick && cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~i_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    // the synchronizer's reset value is not a real observation of the line
    armed_d = armed_q | (settle_q[1] & rxs_q);
`ifdef UART_RX_PARITY_EN
    pend_d  = pend_q;
    perr_d  = 1'b0;
`endif
    if (state_q != IDLE && state_q != START && state_q != WAIT_HIGH && i_tick)
      cnt_d = mid ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (armed_q && !rxs_q) begin
        state_d = START;
        cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
        pend_d  = 1'b0;
`endif
      end
      START: if (i_tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: if (mid) begin
        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == LAST_BIT) state_d = PARITY;
`else
        if (bit_q == LAST_BIT) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) begin
        pend_d  = (^{shift_q, rxs_q}) != PARITY_ODD[0];
        state_d = STOP;
      end
`endif
      STOP: if (mid) begin
        state_d = IDLE;
        if (!rxs_q) begin
          ferr_d  = 1'b1;
          state_d = WAIT_HIGH;
        end
`ifdef UART_RX_PARITY_EN
        else if (pend_q) perr_d = 1'b1;
`endif
        else if (!valid_q || i_ready) begin
          valid_d = 1'b1;
          data_d  = shift_q;
        end else ovr_d = 1'b1;
      end
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q   <= 1'b1;
      rxs_q    <= 1'b1;
      settle_q <= '0;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pend_q   <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      meta_q   <= i_rx;
      rxs_q    <= meta_q;
      settle_q <= {settle_q[0], 1'b1};
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pend_q   <= pend_d;
      perr_q   <= perr_d;
`endif
    end
  end
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed self-checking bench, 8 data bits, 16 ticks/bit, tick every clock.
module tb_uart_rx_framer;
  logic       clk = 1'b0;
  logic       i_rst_n, i_tick, i_rx, i_ready;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_parity_err, o_overrun, o_busy;
  int checks = 0, fails = 0;
  int vcnt = 0, fcnt = 0, pcnt = 0, ocnt = 0, bcnt = 0;
  logic [7:0] last_data = '0;

  uart_rx_framer dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(i_rx), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err),
    .o_parity_err(o_parity_err), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) begin vcnt++; last_data = o_data; end
    if (o_frame_err) fcnt++;
    if (o_parity_err) pcnt++;
    if (o_overrun) ocnt++;
    if (o_busy) bcnt++;
  end

  task automatic clr();
    vcnt = 0; fcnt = 0; pcnt = 0; ocnt = 0; bcnt = 0;
  endtask

  task automatic bit_hold(input logic v);
    i_rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    bit_hold(1'b0);
    for (int i = 0; i < 8; i++) bit_hold(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_hold(par);
`endif
    bit_hold(stop);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_rx = 1'b0; i_tick = 1'b1; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", o_data); end
    checks++; if ({o_frame_err, o_parity_err, o_overrun, o_busy} !== 4'b0)
      begin fails++; $display("FAIL reset_flags got %b want 0000", {o_frame_err, o_parity_err, o_overrun, o_busy}); end
    i_rst_n = 1'b1;
    clr();
    repeat (60) @(negedge clk);
    checks++; if (bcnt !== 0) begin fails++; $display("FAIL low_after_reset_busy got %0d want 0", bcnt); end
    checks++; if (vcnt + fcnt !== 0) begin fails++; $display("FAIL low_after_reset_out got %0d want 0", vcnt + fcnt); end
    idle(40);
  endtask

  task automatic test_basic();
    logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
    for (int k = 0; k < 4; k++) begin
      clr();
      send_frame(pats[k], ^pats[k], 1'b1);
      idle(20);
      checks++; if (vcnt !== 1) begin fails++; $display("FAIL basic_valid_cycles[%0d] got %0d want 1", k, vcnt); end
      checks++; if (last_data !== pats[k]) begin fails++; $display("FAIL basic_data[%0d] got %h want %h", k, last_data, pats[k]); end
      checks++; if (fcnt + pcnt + ocnt !== 0) begin fails++; $display("FAIL basic_errs[%0d] got %0d want 0", k, fcnt + pcnt + ocnt); end
    end
  endtask

  task automatic test_glitch();
    clr();
    i_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    checks++; if (bcnt < 1 || bcnt > 8) begin fails++; $display("FAIL glitch_busy got %0d want 1..8", bcnt); end
    checks++; if (vcnt + fcnt + pcnt + ocnt !== 0) begin fails++; $display("FAIL glitch_out got %0d want 0", vcnt + fcnt + pcnt + ocnt); end
  endtask

  task automatic test_break();
    clr();
    send_frame(8'h3C, 1'b0, 1'b0);
    i_rx = 1'b0;
    repeat (40 * 16) @(negedge clk);
    checks++; if (fcnt !== 1) begin fails++; $display("FAIL break_frame_err got %0d want 1", fcnt); end
    checks++; if (vcnt !== 0) begin fails++; $display("FAIL break_valid got %0d want 0", vcnt); end
    checks++; if (o_busy !== 1'b1) begin fails++; $display("FAIL break_wait_busy got %b want 1", o_busy); end
    idle(40);
    clr();
    send_frame(8'h81, 1'b0, 1'b1);
    idle(20);
    checks++; if (vcnt !== 1 || last_data !== 8'h81) begin fails++; $display("FAIL break_next got %0d/%h want 1/81", vcnt, last_data); end
    checks++; if (fcnt !== 0) begin fails++; $display("FAIL break_next_ferr got %0d want 0", fcnt); end
  endtask

  task automatic test_overrun();
    clr();
    i_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    idle(20);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(20);
    checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b want 1", o_valid); end
    checks++; if (o_data !== 8'h11) begin fails++; $display("FAIL ovr_data got %h want 11", o_data); end
    checks++; if (ocnt !== 1) begin fails++; $display("FAIL ovr_pulses got %0d want 1", ocnt); end
    i_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL ovr_drop got %b want 0", o_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] f0 = 8'hF0;
    i_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1);
    idle(10);
    bit_hold(1'b0);
    for (int i = 0; i < 4; i++) bit_hold(f0[i]);
    i_rx = f0[4];
    repeat (8) @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin fails++; $display("FAIL midreset_out got %b/%h want 0/00", o_valid, o_data); end
    checks++; if (o_busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", o_busy); end
    @(negedge clk);
    i_rx = 1'b1; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    i_rst_n = 1'b1;
    idle(20);
    clr();
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(20);
    checks++; if (vcnt !== 1 || last_data !== 8'h5A) begin fails++; $display("FAIL midreset_next got %0d/%h want 1/5a", vcnt, last_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clr();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    checks++; if (vcnt !== 1 || last_data !== 8'h07) begin fails++; $display("FAIL parity_good got %0d/%h want 1/07", vcnt, last_data); end
    clr();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    checks++; if (pcnt !== 1) begin fails++; $display("FAIL parity_err got %0d want 1", pcnt); end
    checks++; if (vcnt !== 0) begin fails++; $display("FAIL parity_err_valid got %0d want 0", vcnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
